// File: rtl/axi_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_pkg
// Brief   : Shared encodings for the AXI write-side command decoder:
//           burst types, B-channel response codes and decoder FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package axi_wr_pkg;

    // AXI burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Decoder FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_BURST = 3'd3,
        S_RESP  = 3'd4,
        S_DRAIN = 3'd5
    } wr_state_e;

endpackage : axi_wr_pkg
`default_nettype wire

// File: rtl/axi_wr_data_fifo.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_data_fifo
// Brief   : Synchronous FIFO buffering write-data beats (data + strobes).
//           Head entry is presented combinationally; reads as 0 when empty.
// Revision: 1.0 - initial release
// ============================================================================
module axi_wr_data_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic                       AClk,
    input  logic                       ARst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             w_push;
    logic             w_pop;

    // A pop frees a slot in the same cycle, so a full FIFO may push while popping
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents need no reset since the head is masked when empty
    always_ff @(posedge AClk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : axi_wr_data_fifo
`default_nettype wire

// File: rtl/axi_wr_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_cmd_decoder
// Brief   : Write-side decoder feeding the AXI master write control stage.
//           Buffers burst data, issues one transaction at a time and returns
//           the B-channel result to the host as a response token.
//           Optional macro WR_DEC_ID_CHECK_EN: compare bid_d against the
//           latched command ID and flag SLVERR/proto_err on a mismatch.
// Revision: 1.0 - initial release
// ============================================================================
module axi_wr_cmd_decoder
    import axi_wr_pkg::*;
#(
    parameter int addr_width   = 32,
    parameter int data_width   = 64,
    parameter int strobe_width = data_width / 8,
    parameter int DATA_DEPTH   = 16
) (
    input  logic                    AClk,
    input  logic                    ARst,
    // host command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [3:0]              cmd_id,
    input  logic [1:0]              cmd_burst,
    input  logic [3:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_lock,
    input  logic [1:0]              cmd_cache,
    input  logic [2:0]              cmd_prot,
    // host write data
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [data_width-1:0]   wd_data,
    input  logic [strobe_width-1:0] wd_strb,
    // to write control
    output logic [addr_width-1:0]   awaddr_d,
    output logic [3:0]              TXN_ID_W_d,
    output logic [1:0]              awburst_d,
    output logic [3:0]              awlen_d,
    output logic [2:0]              awsize_d,
    output logic [1:0]              awlock_d,
    output logic [1:0]              awcache_d,
    output logic [2:0]              awprot_d,
    output logic [data_width-1:0]   wdata_d,
    output logic [strobe_width-1:0] wstrb_d,
    output logic                    wr_trn_en,
    input  logic                    w_beat_acc,
    // from write control
    input  logic [1:0]              bresp_d,
    input  logic [3:0]              bid_d,
    input  logic                    wr_rsp_en_d,
    // host response
    output logic                    rsp_valid,
    output logic [3:0]              rsp_id,
    output logic [1:0]              rsp_resp,
    output logic                    proto_err
);

    localparam int FIFO_W = data_width + strobe_width;
    localparam int CNT_W  = $clog2(DATA_DEPTH) + 1;
    localparam int BEAT_W = 5;

    wr_state_e              state_q, state_d;

    logic [addr_width-1:0]  addr_q,  addr_d;
    logic [3:0]             id_q,    id_d;
    logic [1:0]             burst_q, burst_d;
    logic [3:0]             len_q,   len_d;
    logic [2:0]             size_q,  size_d;
    logic [1:0]             lock_q,  lock_d;
    logic [1:0]             cache_q, cache_d;
    logic [2:0]             prot_q,  prot_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic [3:0]             rsp_id_q,    rsp_id_d;
    logic [1:0]             rsp_resp_q,  rsp_resp_d;
    logic                   proto_err_q, proto_err_d;

    logic                   w_fifo_push;
    logic                   w_fifo_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CNT_W-1:0]       w_fifo_count;
    logic [FIFO_W-1:0]      w_fifo_rdata;
    logic                   w_cmd_active;

    // Data buffer: filled from the host independently of the command flow
    axi_wr_data_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .AClk    (AClk),
        .ARst    (ARst),
        .push_i  (w_fifo_push),
        .pop_i   (w_fifo_pop),
        .wdata_i ({wd_strb, wd_data}),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Ready outputs are forced low while reset is held so every output reads 0
    assign wd_ready    = ARst && !w_fifo_full;
    assign cmd_ready   = ARst && (state_q == S_IDLE);
    assign w_fifo_push = wd_valid && wd_ready;

    assign wdata_d     = w_fifo_rdata[data_width-1:0];
    assign wstrb_d     = w_fifo_rdata[FIFO_W-1:data_width];

    // Command fields are visible to write control only while a real transaction is live
    assign w_cmd_active = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                          (state_q == S_BURST) || (state_q == S_RESP);
    assign awaddr_d    = w_cmd_active ? addr_q  : '0;
    assign TXN_ID_W_d  = w_cmd_active ? id_q    : '0;
    assign awburst_d   = w_cmd_active ? burst_q : '0;
    assign awlen_d     = w_cmd_active ? len_q   : '0;
    assign awsize_d    = w_cmd_active ? size_q  : '0;
    assign awlock_d    = w_cmd_active ? lock_q  : '0;
    assign awcache_d   = w_cmd_active ? cache_q : '0;
    assign awprot_d    = w_cmd_active ? prot_q  : '0;
    assign wr_trn_en   = (state_q == S_ISSUE);

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_resp    = rsp_resp_q;
    assign proto_err   = proto_err_q;

    // FSM state register
    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Latched command fields, beat counter and response registers
    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            addr_q      <= '0;
            id_q        <= '0;
            burst_q     <= '0;
            len_q       <= '0;
            size_q      <= '0;
            lock_q      <= '0;
            cache_q     <= '0;
            prot_q      <= '0;
            beat_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_resp_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            id_q        <= id_d;
            burst_q     <= burst_d;
            len_q       <= len_d;
            size_q      <= size_d;
            lock_q      <= lock_d;
            cache_q     <= cache_d;
            prot_q      <= prot_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_resp_q  <= rsp_resp_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state, FIFO pop and response generation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        id_d        = id_q;
        burst_d     = burst_q;
        len_d       = len_q;
        size_d      = size_q;
        lock_d      = lock_q;
        cache_d     = cache_q;
        prot_d      = prot_q;
        beat_cnt_d  = beat_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_resp_d  = rsp_resp_q;
        proto_err_d = proto_err_q;
        w_fifo_pop  = 1'b0;

        // Stray handshakes from write control are ignored but remembered
        if (w_beat_acc && (state_q != S_BURST))   proto_err_d = 1'b1;
        if (wr_rsp_en_d && (state_q != S_RESP))   proto_err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    id_d    = cmd_id;
                    burst_d = cmd_burst;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    lock_d  = cmd_lock;
                    cache_d = cmd_cache;
                    prot_d  = cmd_prot;
                    if (cmd_burst == BURST_RSVD) begin
                        beat_cnt_d = {1'b0, cmd_len} + BEAT_W'(1);
                        state_d    = S_DRAIN;
                    end else begin
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // Whole burst must be buffered so W never stalls once issued
                if (w_fifo_count >= (CNT_W'(len_q) + CNT_W'(1))) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                beat_cnt_d = {1'b0, len_q} + BEAT_W'(1);
                state_d    = S_BURST;
            end
            S_BURST: begin
                if (w_beat_acc) begin
                    if (w_fifo_empty) begin
                        proto_err_d = 1'b1;
                    end else begin
                        w_fifo_pop = 1'b1;
                        beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                        if (beat_cnt_q == BEAT_W'(1)) state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (wr_rsp_en_d) begin
                    rsp_valid_d = 1'b1;
`ifdef WR_DEC_ID_CHECK_EN
                    rsp_id_d    = id_q;
                    rsp_resp_d  = bresp_d;
                    if (bid_d != id_q) begin
                        rsp_resp_d  = RESP_SLVERR;
                        proto_err_d = 1'b1;
                    end
`else
                    rsp_id_d    = bid_d;
                    rsp_resp_d  = bresp_d;
`endif
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Reserved burst: discard its data and answer SLVERR locally
                if (!w_fifo_empty) begin
                    w_fifo_pop = 1'b1;
                    beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(1)) begin
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = id_q;
                        rsp_resp_d  = RESP_SLVERR;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule : axi_wr_cmd_decoder
`default_nettype wire

// File: tb/tb_axi_wr_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_wr_cmd_decoder
// Brief   : Directed self-checking bench for axi_wr_cmd_decoder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_wr_cmd_decoder;

    logic        AClk = 1'b0;
    logic        ARst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_id;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_lock;
    logic [1:0]  cmd_cache;
    logic [2:0]  cmd_prot;
    logic        wd_valid;
    logic        wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic [31:0] awaddr_d;
    logic [3:0]  TXN_ID_W_d;
    logic [1:0]  awburst_d;
    logic [3:0]  awlen_d;
    logic [2:0]  awsize_d;
    logic [1:0]  awlock_d;
    logic [1:0]  awcache_d;
    logic [2:0]  awprot_d;
    logic [63:0] wdata_d;
    logic [7:0]  wstrb_d;
    logic        wr_trn_en;
    logic        w_beat_acc;
    logic [1:0]  bresp_d;
    logic [3:0]  bid_d;
    logic        wr_rsp_en_d;
    logic        rsp_valid;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic        proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic seen_trn;

    always #5 AClk = ~AClk;

    axi_wr_cmd_decoder u_dut (
        .AClk(AClk), .ARst(ARst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_id(cmd_id), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_lock(cmd_lock), .cmd_cache(cmd_cache),
        .cmd_prot(cmd_prot),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .awaddr_d(awaddr_d), .TXN_ID_W_d(TXN_ID_W_d), .awburst_d(awburst_d),
        .awlen_d(awlen_d), .awsize_d(awsize_d), .awlock_d(awlock_d),
        .awcache_d(awcache_d), .awprot_d(awprot_d),
        .wdata_d(wdata_d), .wstrb_d(wstrb_d), .wr_trn_en(wr_trn_en),
        .w_beat_acc(w_beat_acc), .bresp_d(bresp_d), .bid_d(bid_d),
        .wr_rsp_en_d(wr_rsp_en_d),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
        .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge AClk);
        #1;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] s);
        wd_valid = 1'b1;
        wd_data  = d;
        wd_strb  = s;
        tick();
        wd_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [3:0] id,
                            input logic [1:0] b, input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_id    = id;
        cmd_burst = b;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic respond(input logic [3:0] id, input logic [1:0] r);
        wr_rsp_en_d = 1'b1;
        bid_d       = id;
        bresp_d     = r;
        tick();
        wr_rsp_en_d = 1'b0;
    endtask

    task automatic beat_acc();
        w_beat_acc = 1'b1;
        tick();
        w_beat_acc = 1'b0;
    endtask

    initial begin
        ARst = 1'b0;
        cmd_valid = 0; cmd_addr = 0; cmd_id = 0; cmd_burst = 0; cmd_len = 0;
        cmd_size = 3'd3; cmd_lock = 0; cmd_cache = 2'd1; cmd_prot = 3'd2;
        wd_valid = 0; wd_data = 0; wd_strb = 0;
        w_beat_acc = 0; bresp_d = 0; bid_d = 0; wr_rsp_en_d = 0;
        tick(); tick();

        // ---- reset state ----
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wd_ready",  wd_ready,  0);
        chk("rst_trn",       wr_trn_en, 0);
        chk("rst_wdata",     wdata_d,   0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_proto_err", proto_err, 0);
        ARst = 1'b1;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_awaddr",    awaddr_d,  0);

        // ---- single beat ----
        push_beat(64'hA5, 8'hFF);
        chk("sb_wdata_head", wdata_d, 64'hA5);
        chk("sb_wstrb_head", wstrb_d, 8'hFF);
        send_cmd(32'h1000, 4'd3, 2'b01, 4'd0);
        chk("sb_load_awaddr", awaddr_d,   32'h1000);
        chk("sb_load_id",     TXN_ID_W_d, 3);
        chk("sb_load_size",   awsize_d,   3);
        chk("sb_load_trn",    wr_trn_en,  0);
        chk("sb_busy_ready",  cmd_ready,  0);
        tick();
        chk("sb_issue_trn",   wr_trn_en,  1);
        tick();
        chk("sb_burst_trn",   wr_trn_en,  0);
        chk("sb_burst_wdata", wdata_d,    64'hA5);
        beat_acc();
        chk("sb_resp_empty",  wdata_d,    0);
        chk("sb_resp_hold",   awaddr_d,   32'h1000);
        respond(4'd3, 2'b00);
        chk("sb_rsp_valid",   rsp_valid,  1);
        chk("sb_rsp_id",      rsp_id,     3);
        chk("sb_rsp_resp",    rsp_resp,   0);
        chk("sb_idle_awaddr", awaddr_d,   0);
        tick();
        chk("sb_rsp_pulse",   rsp_valid,  0);

        // ---- burst of 16, data buffered before the command ----
        for (int i = 0; i < 16; i++) push_beat(64'(i), 8'(i));
        chk("b16_full_ready", wd_ready, 0);
        send_cmd(32'h2000, 4'd7, 2'b01, 4'd15);
        chk("b16_awlen",   awlen_d,   15);
        chk("b16_awburst", awburst_d, 1);
        tick();
        chk("b16_issue",   wr_trn_en, 1);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("b16_beat_data", wdata_d, 64'(i));
            chk("b16_beat_strb", wstrb_d, 64'(i));
            beat_acc();
        end
        chk("b16_empty",     wdata_d,   0);
        chk("b16_ready",     wd_ready,  1);
        chk("b16_resp_hold", TXN_ID_W_d, 7);
        respond(4'd7, 2'b01);
        chk("b16_rsp_valid", rsp_valid, 1);
        chk("b16_rsp_id",    rsp_id,    7);
        chk("b16_rsp_resp",  rsp_resp,  1);
        tick();

        // ---- late data: one beat every five cycles ----
        send_cmd(32'h3000, 4'd1, 2'b01, 4'd3);
        seen_trn = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_trn_en) seen_trn = 1'b1;
                tick();
            end
            push_beat(64'h30 + 64'(b), 8'h0F);
        end
        chk("late_no_early_trn", seen_trn, 0);
        chk("late_still_load",   wr_trn_en, 0);
        tick();
        chk("late_issue",        wr_trn_en, 1);
        tick();
        for (int b = 0; b < 4; b++) begin
            chk("late_beat", wdata_d, 64'h30 + 64'(b));
            beat_acc();
        end
        respond(4'd1, 2'b00);
        chk("late_rsp_valid", rsp_valid, 1);
        chk("late_rsp_id",    rsp_id,    1);
        tick();

        // ---- reserved burst: drained and answered locally ----
        seen_trn = 1'b0;
        push_beat(64'h11, 8'h01);
        send_cmd(32'h4000, 4'd4, 2'b11, 4'd1);
        if (wr_trn_en) seen_trn = 1'b1;
        chk("rsvd_no_awaddr", awaddr_d, 0);
        tick();
        if (wr_trn_en) seen_trn = 1'b1;
        chk("rsvd_first_pop", wdata_d,  0);
        chk("rsvd_wait",      rsp_valid, 0);
        push_beat(64'h22, 8'h02);
        chk("rsvd_second_in", wdata_d,  64'h22);
        tick();
        if (wr_trn_en) seen_trn = 1'b1;
        chk("rsvd_rsp_valid", rsp_valid, 1);
        chk("rsvd_rsp_id",    rsp_id,    4);
        chk("rsvd_rsp_resp",  rsp_resp,  2);
        chk("rsvd_drained",   wdata_d,   0);
        chk("rsvd_no_trn",    seen_trn,  0);
        chk("clean_proto",    proto_err, 0);
        tick();

        // ---- errors: stray beat accept in IDLE, then ID mismatch ----
        push_beat(64'h55, 8'hAA);
        beat_acc();
        chk("err_idle_acc",  proto_err, 1);
        chk("err_fifo_keep", wdata_d,   64'h55);
        send_cmd(32'h5000, 4'd2, 2'b01, 4'd0);
        tick();
        chk("err_issue", wr_trn_en, 1);
        tick();
        beat_acc();
        respond(4'd5, 2'b00);
        chk("id_rsp_valid", rsp_valid, 1);
`ifdef WR_DEC_ID_CHECK_EN
        chk("id_rsp_id",   rsp_id,   2);
        chk("id_rsp_resp", rsp_resp, 2);
`else
        chk("id_rsp_id",   rsp_id,   5);
        chk("id_rsp_resp", rsp_resp, 0);
`endif
        tick();

        // ---- reset mid-burst after 2 of 4 beats ----
        for (int i = 0; i < 4; i++) push_beat(64'h60 + 64'(i), 8'hFF);
        send_cmd(32'h6000, 4'd6, 2'b01, 4'd3);
        tick();
        chk("mid_issue", wr_trn_en, 1);
        tick();
        beat_acc();
        beat_acc();
        chk("mid_third_beat", wdata_d, 64'h62);
        ARst = 1'b0;
        #2;
        chk("mid_rst_awaddr", awaddr_d,  0);
        chk("mid_rst_wdata",  wdata_d,   0);
        chk("mid_rst_proto",  proto_err, 0);
        chk("mid_rst_ready",  cmd_ready, 0);
        tick();
        ARst = 1'b1;
        seen_trn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid || wr_trn_en) seen_trn = 1'b1;
            tick();
        end
        chk("mid_no_rsp",     seen_trn,  0);
        chk("mid_fifo_empty", wdata_d,   0);
        chk("mid_idle_ready", cmd_ready, 1);

        // ---- stray response outside RESP ----
        respond(4'd6, 2'b00);
        chk("stray_rsp_err",   proto_err, 1);
        chk("stray_rsp_valid", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axi_wr_cmd_decoder
`default_nettype wire
